load_unit: RTL

Multi-cycle memory read engine for the multi-cycle RISC-V core. It is the read-side counterpart of the datapath's write-enabled state registers. When the control FSM reaches its memory-read step, it issues a word-aligned request to data memory, waits for the response, and extracts and sign/zero-extends the addressed byte, half or word. The result is held for write-back into the register file.

---
 rtl/load_pkg.sv | 34 +++
 rtl/load_extract.sv | 27 ++
 rtl/load_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/load_pkg.sv
// Shared encodings for the load unit: funct3 load types, FSM states, fault codes
// and the fault decode applied when a request is accepted.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Unknown funct3 wins over alignment because it is decoded first.
  function automatic logic [1:0] decode_fault(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return FLT_OK;
      F3_LH, F3_LHU: return off[0] ? FLT_MISALIGN : FLT_OK;
      F3_LW:         return (off != 2'b00) ? FLT_MISALIGN : FLT_OK;
      default:       return FLT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word from a little-endian memory word and
// sign- or zero-extends it according to the load type.
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle memory read engine: issues a word-aligned read, waits for the
// response with a timeout, and holds the extended result for write-back.
module load_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [7:0]  cnt;
  logic [31:0] ext_data;
  logic [1:0]  start_fault;

  assign start_fault = decode_fault(funct3, addr[1:0]);

  load_extract u_extract (
    .word   (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  // done/fault are set on the transition into DONE/ERR so they are visible
  // for exactly the one cycle spent there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= FLT_OK;
      rd_data  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt      <= '0;
      off_q    <= '0;
      f3_q     <= '0;
    end else begin
      done  <= 1'b0;
      fault <= FLT_OK;
      case (state)
        S_IDLE: begin
          if (start) begin
            off_q    <= addr[1:0];
            f3_q     <= funct3;
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            if (start_fault != FLT_OK) begin
              state <= S_ERR;
              done  <= 1'b1;
              fault <= start_fault;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              rd_data <= ext_data;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              cnt   <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rd_data <= ext_data;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (cnt == TO_LAST) begin
            done  <= 1'b1;
            fault <= FLT_TIMEOUT;
            state <= S_ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
